// File: rtl/tcls_recovery_ctrl.sv
// Recovery sequencer for a triple-core lockstep system: quiesces the AHB buses
// on an unrecoverable discrepancy, drains them, resets the cores, escalates to FATAL.
module tcls_recovery_ctrl #(
    parameter int RST_CYCLES   = 8,
    parameter int DRAIN_MAX    = 16,
    parameter int MAX_RETRIES  = 3,
    parameter int QUIET_CYCLES = 1024
) (
    input  logic       s_clk_i,
    input  logic       s_resetn_i,
    input  logic       s_unrec_err_i,
    input  logic       s_i_hready_i,
    input  logic       s_d_hready_i,
    output logic       s_core_resetn_o,
    output logic       s_bus_block_o,
    output logic       s_busy_o,
    output logic       s_fatal_o,
    output logic [7:0] s_err_cnt_o
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int DW = $clog2(DRAIN_MAX + 1);
    localparam int TW = $clog2(MAX_RETRIES + 1);
    localparam int QW = $clog2(QUIET_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_RESET = 2'd2,
        ST_FATAL = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [TW-1:0]   retry_cnt_q, retry_cnt_d;
    logic [QW-1:0]   quiet_cnt_q, quiet_cnt_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            core_resetn_q, bus_block_q, busy_q, fatal_q;
    logic            drained_s;

    assign drained_s = s_i_hready_i & s_d_hready_i;

    // Next-state and counter updates
    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        drain_cnt_d = drain_cnt_q;
        retry_cnt_d = retry_cnt_q;
        quiet_cnt_d = quiet_cnt_q;
        err_cnt_d   = err_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (s_unrec_err_i) begin
                    // An error wins over a coincident quiet-interval clear.
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end else begin
                        err_cnt_d = err_cnt_q;
                    end
                    if (retry_cnt_q == TW'(MAX_RETRIES)) begin
                        state_d = ST_FATAL;
                    end else begin
                        state_d     = ST_DRAIN;
                        retry_cnt_d = retry_cnt_q + TW'(1);
                        quiet_cnt_d = '0;
                        drain_cnt_d = '0;
                    end
                end else if (quiet_cnt_q == QW'(QUIET_CYCLES - 1)) begin
                    quiet_cnt_d = '0;
                    retry_cnt_d = '0;
                end else begin
                    quiet_cnt_d = quiet_cnt_q + QW'(1);
                end
            end
            ST_DRAIN: begin
                if (drained_s) begin
                    state_d   = ST_RESET;
                    rst_cnt_d = '0;
                end else if (drain_cnt_q == DW'(DRAIN_MAX - 1)) begin
                    state_d = ST_FATAL;
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
            end
            ST_RESET: begin
                if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
                    state_d   = ST_RUN;
                    rst_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RW'(1);
                end
            end
            ST_FATAL: begin
                state_d = ST_FATAL;
            end
            default: begin
                state_d = ST_FATAL;
            end
        endcase
    end

    // State, counters and output registers; outputs decode the next state so
    // they change on the same edge as the state register.
    always_ff @(posedge s_clk_i) begin
        if (!s_resetn_i) begin
            state_q       <= ST_RESET;
            rst_cnt_q     <= '0;
            drain_cnt_q   <= '0;
            retry_cnt_q   <= '0;
            quiet_cnt_q   <= '0;
            err_cnt_q     <= 8'd0;
            core_resetn_q <= 1'b0;
            bus_block_q   <= 1'b1;
            busy_q        <= 1'b1;
            fatal_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            retry_cnt_q   <= retry_cnt_d;
            quiet_cnt_q   <= quiet_cnt_d;
            err_cnt_q     <= err_cnt_d;
            core_resetn_q <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
            bus_block_q   <= (state_d != ST_RUN);
            busy_q        <= (state_d != ST_RUN);
            fatal_q       <= (state_d == ST_FATAL);
        end
    end

    assign s_core_resetn_o = core_resetn_q;
    assign s_bus_block_o   = bus_block_q;
    assign s_busy_o        = busy_q;
    assign s_fatal_o       = fatal_q;
    assign s_err_cnt_o     = err_cnt_q;

endmodule
